// File: rtl/sdio_cmd_sniffer.sv
// sdio_cmd_sniffer: passive SD/SDIO CMD-line monitor.
// Captures each host command frame and the matching card response (none,
// 48-bit or 136-bit, chosen per command index), with a response timeout.
// Each transaction is published as one record on a valid/ready output;
// an unread record is overwritten by the next one and flagged as overrun.
// Optional feature: define SDIO_CMD_CRC7_EN to check CRC7 on command and
// response; without it cap_crc_err is tied low.
module sdio_cmd_sniffer #(
    parameter int unsigned MAXLAT      = 64,
    parameter logic [63:0] NORESP_MASK = 64'h0000_0000_0000_8011,
    parameter logic [63:0] LONG_MASK   = 64'h0000_0000_0000_0604,
    parameter logic [63:0] NOCRC_MASK  = 64'h0000_0200_0000_0020
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         sd_en,
    input  logic         cmd_i,
    output logic         cap_valid,
    input  logic         cap_ready,
    output logic [5:0]   cap_cmd,
    output logic [31:0]  cap_arg,
    output logic [127:0] cap_resp,
    output logic         cap_resp_present,
    output logic         cap_resp_long,
    output logic         cap_timeout,
    output logic         cap_crc_err,
    output logic         cap_overrun,
    output logic [2:0]   state
);

    localparam int unsigned CNT_MAX = (MAXLAT + 1 > 137) ? (MAXLAT + 1) : 137;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] CMD_BITS   = CW'(48);
    localparam logic [CW-1:0] SHORT_BITS = CW'(48);
    localparam logic [CW-1:0] LONG_BITS  = CW'(136);
    localparam logic [CW-1:0] LAT_LAST   = CW'(MAXLAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CMD   = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         st, st_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           clr;
    logic           cmd_q;
    logic [47:0]    cmd_sr;
    logic [135:0]   resp_sr;
    logic           resp_got;
    logic           timed_out;
    logic           cmd_shift;
    logic           resp_shift;
    logic           resp_end;
    logic           timeout_hit;
    logic           load;
    logic [5:0]     idx;
    logic           is_long;
    logic [CW-1:0]  resp_len;
    logic           crc_bad;
    logic           unused_bits;

    assign clr      = rst | ~sd_en;
    assign idx      = cmd_sr[45:40];
    assign is_long  = LONG_MASK[idx];
    assign resp_len = is_long ? LONG_BITS : SHORT_BITS;
    assign state    = st;

    // Input register: the FSM only ever looks at the registered CMD line.
    always_ff @(posedge sd_clk) begin
        if (clr) cmd_q <= 1'b1;
        else     cmd_q <= cmd_i;
    end

    // State and shared bit/latency counter registers.
    always_ff @(posedge sd_clk) begin
        if (clr) begin
            st  <= S_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Next-state logic; a frame is complete one cycle after its last bit is shifted.
    always_comb begin
        st_nxt      = st;
        cnt_nxt     = cnt;
        cmd_shift   = 1'b0;
        resp_shift  = 1'b0;
        resp_end    = 1'b0;
        timeout_hit = 1'b0;
        load        = 1'b0;
        case (st)
            S_IDLE: begin
                if (!cmd_q) begin
                    cmd_shift = 1'b1;
                    cnt_nxt   = CW'(1);
                    st_nxt    = S_START;
                end
            end
            S_START: begin
                if (cmd_q) begin
                    cmd_shift = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                    st_nxt    = S_CMD;
                end else begin
                    cnt_nxt = '0;
                    st_nxt  = S_IDLE;
                end
            end
            S_CMD: begin
                if (cnt == CMD_BITS) begin
                    cnt_nxt = '0;
                    st_nxt  = NORESP_MASK[idx] ? S_DONE : S_WAIT;
                end else begin
                    cmd_shift = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (!cmd_q) begin
                    resp_shift = 1'b1;
                    cnt_nxt    = CW'(1);
                    st_nxt     = S_RESP;
                end else if (cnt == LAT_LAST) begin
                    timeout_hit = 1'b1;
                    cnt_nxt     = CW'(MAXLAT);
                    st_nxt      = S_DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RESP: begin
                if (cnt == resp_len) begin
                    resp_end = 1'b1;
                    cnt_nxt  = '0;
                    st_nxt   = S_DONE;
                end else begin
                    resp_shift = 1'b1;
                    cnt_nxt    = cnt + CW'(1);
                end
            end
            S_DONE: begin
                load    = 1'b1;
                cnt_nxt = '0;
                st_nxt  = S_IDLE;
            end
            default: begin
                cnt_nxt = '0;
                st_nxt  = S_IDLE;
            end
        endcase
    end

    // Frame shift registers and per-transaction status flags.
    always_ff @(posedge sd_clk) begin
        if (clr) begin
            cmd_sr    <= '0;
            resp_sr   <= '0;
            resp_got  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            if (cmd_shift)   cmd_sr  <= {cmd_sr[46:0], cmd_q};
            if (resp_shift)  resp_sr <= {resp_sr[134:0], cmd_q};
            if (resp_end)    resp_got  <= 1'b1;
            if (timeout_hit) timed_out <= 1'b1;
            if (load) begin
                resp_got  <= 1'b0;
                timed_out <= 1'b0;
            end
        end
    end

`ifdef SDIO_CMD_CRC7_EN
    logic [6:0]    crc_c;
    logic [6:0]    crc_r;
    logic [CW-1:0] rpos;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // The response start bit arrives in WAIT, where cnt still holds latency.
    assign rpos = (st == S_WAIT) ? '0 : cnt;

    // Serial CRC7: command over bits 47..8, response over 47..8 (short) or 127..8 (long).
    always_ff @(posedge sd_clk) begin
        if (clr) begin
            crc_c <= '0;
            crc_r <= '0;
        end else begin
            if (cmd_shift && (cnt < CW'(40)))
                crc_c <= crc7_step((cnt == '0) ? 7'd0 : crc_c, cmd_q);
            if (resp_shift) begin
                if (rpos == '0)
                    crc_r <= is_long ? 7'd0 : crc7_step(7'd0, cmd_q);
                else if (is_long ? ((rpos >= CW'(8)) && (rpos < CW'(128))) : (rpos < CW'(40)))
                    crc_r <= crc7_step(crc_r, cmd_q);
            end
        end
    end

    assign crc_bad = (crc_c != cmd_sr[7:1]) |
                     (resp_got & ~NOCRC_MASK[idx] & (crc_r != resp_sr[7:1]));
    assign unused_bits = ^{cmd_sr[47:46], cmd_sr[0], resp_sr[135:128], resp_sr[0]};
`else
    assign crc_bad     = 1'b0;
    assign unused_bits = ^{cmd_sr[47:46], cmd_sr[7:0], resp_sr[135:128], resp_sr[0], NOCRC_MASK};
`endif

    // Output record: load on DONE (overwriting an unread record), clear valid on accept.
    always_ff @(posedge sd_clk) begin
        if (clr) begin
            cap_valid        <= 1'b0;
            cap_cmd          <= '0;
            cap_arg          <= '0;
            cap_resp         <= '0;
            cap_resp_present <= 1'b0;
            cap_resp_long    <= 1'b0;
            cap_timeout      <= 1'b0;
            cap_crc_err      <= 1'b0;
            cap_overrun      <= 1'b0;
        end else if (load) begin
            cap_valid        <= 1'b1;
            cap_cmd          <= idx;
            cap_arg          <= cmd_sr[39:8];
            cap_resp         <= !resp_got ? '0 :
                                is_long   ? {1'b0, resp_sr[127:1]} :
                                            {96'd0, resp_sr[39:8]};
            cap_resp_present <= resp_got;
            cap_resp_long    <= resp_got & is_long;
            cap_timeout      <= timed_out;
            cap_crc_err      <= crc_bad;
            cap_overrun      <= cap_valid & ~cap_ready;
        end else if (cap_valid && cap_ready) begin
            cap_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sdio_cmd_sniffer.md
# sdio_cmd_sniffer

Passive SD/SDIO CMD-line monitor, successor to the single-purpose command sampler. Decodes host command frames and the matching card response on one CMD pin, with parametrised response-type tables and response timeout. Delivers each transaction as one record over a valid/ready interface with overrun flagging. Sits beside the SD pins, feeding the SPI-side debug/trace logic.

## Interface
- MAXLAT, 64: max sd_clk cycles between command end bit and response start bit.
- NORESP_MASK, 64'h0000_0000_0000_8011: bit n set → CMDn has no response (CMD0, CMD4, CMD15).
- LONG_MASK, 64'h0000_0000_0000_0604: bit n set → CMDn has 136-bit response (CMD2, CMD9, CMD10).
- NOCRC_MASK, 64'h0000_0200_0000_0020: bit n set → response CRC not checked (CMD5, CMD41).
- sd_clk  in  1  CMD-line clock; only clock.
- rst  in  1  synchronous, active-high reset.
- sd_en  in  1  capture enable; low acts as synchronous reset of FSM and input register.
- cmd_i  in  1  raw CMD line.
- cap_valid  out  1  record available.
- cap_ready  in  1  consumer accepts record.
- cap_cmd  out  6  command index.
- cap_arg  out  32  command argument.
- cap_resp  out  128  response payload.
- cap_resp_present  out  1  response captured.
- cap_resp_long  out  1  response was 136 bits.
- cap_timeout  out  1  expected response not seen within MAXLAT.
- cap_crc_err  out  1  CRC7 mismatch on command or response.
- cap_overrun  out  1  previous unread record was overwritten.
- state  out  3  current FSM state, debug.

## Operation
- Reset (rst=1 or sd_en=0): all outputs 0, state=IDLE, cmd_q=1; any partial frame discarded.
- cmd_q registers cmd_i each edge; FSM consumes only cmd_q.
- IDLE: cmd_q=0 → START. START: cmd_q=1 (host direction) → CMD; cmd_q=0 → IDLE (no capture).
- CMD: shift until 48 bits held; then index=frame[45:40]. NORESP_MASK[index] → DONE, else → WAIT.
- WAIT: latency counter from 0; cmd_q=0 → RESP; counter reaches MAXLAT → DONE, timeout=1.
- RESP: shift until 48 or 136 bits (by LONG_MASK[index]) → DONE. Response transmission bit not checked.
- DONE: load output record, → IDLE in one cycle; next start bit detectable the following cycle.
- cap_arg = cmd frame[39:8]. Short: cap_resp = {96'b0, resp[39:8]}. Long: cap_resp = {1'b0, resp[127:1]}. No response/timeout: cap_resp=0, cap_resp_present=0.
- Output register: cap_valid held, fields stable, until cap_valid & cap_ready edge, then cap_valid=0.
- DONE load while cap_valid=1 and cap_ready=0: new record replaces old, cap_overrun=1. Load coincident with accept: new record, cap_overrun=0.

## Timing
- Edge E samples end bit on cmd_i; record fields and cap_valid visible after edge E+3 (cmd_q, shift-complete, DONE load).
- Timeout: cap_valid visible MAXLAT+3 edges after command end-bit sample.
- cap_valid to accept: combinational cap_ready, zero added latency; no back-pressure on capture (overwrite policy).
- Counters sized ceil(log2(max(137, MAXLAT+1))); no wrap in any state.

## Configuration
- SDIO_CMD_CRC7_EN defined: CRC7 (x^7+x^3+1) over command bits [47:8] vs [7:1]; over short response [47:8] or long response [127:8] vs [7:1], skipped when NOCRC_MASK[index]; any mismatch → cap_crc_err=1 in that record.
- Undefined: no CRC logic; cap_crc_err tied 0.

## Test plan
- CMD17 arg 0x0000_1000 valid CRC, R1 0x0000_0900 after 5 cycles → cap_cmd=17, cap_arg=0x1000, cap_resp=0x900, present=1, long=0, errors 0, valid at E+3.
- CMD0 arg 0 → record with present=0, timeout=0, no WAIT entry.
- CMD2 then 136-bit R2 with CID 0x1122…EEFF → long=1, cap_resp holds resp[127:1] exactly.
- CMD8 with cmd_i held 1 → cap_timeout=1 exactly MAXLAT+3 edges after end bit.
- Two transactions, cap_ready=0 → second record present, cap_overrun=1; cap_ready pulse → cap_valid=0.
- SDIO_CMD_CRC7_EN: flip one CRC bit in CMD17 → cap_crc_err=1; CMD41 R3 with CRC 7'h7F → cap_crc_err=0. rst mid-CMD → no record, state=IDLE.
